sine_nco: RTL and testbench

- Numerically controlled oscillator that sits directly upstream of the 256-entry, 21-bit dual-port sine lookup table.
- Accumulates phase by a frequency control word and drives both LUT read ports with adjacent addresses.
- Linearly interpolates the two returned words using the next 8 phase bits.
- Presents each sample on a valid/ready output to the audio/PWM consumer.

---
 rtl/sine_nco.sv | 155 +++++++++++++++
 tb/tb_sine_nco.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_nco.sv
// sine_nco: phase-accumulating oscillator feeding a 256-entry dual-port
// sine LUT. Adjacent table words are fetched together and blended with the
// next 8 phase bits to give a 21-bit signed sample on a valid/ready port.
//
// Output handshake: o_sample_valid rises with a new o_sample and both hold
// stable until the cycle where i_sample_ready is also high; that cycle is
// the transfer, and valid drops on the following edge.
module sine_nco #(
    parameter int PHASE_WIDTH = 24
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic [PHASE_WIDTH-1:0] i_fcw,
    input  logic                   i_phase_clear,
    output logic                   o_lut_ena,
    output logic [7:0]             o_lut_addra,
    input  logic [20:0]            i_lut_douta,
    output logic                   o_lut_enb,
    output logic [7:0]             o_lut_addrb,
    input  logic [20:0]            i_lut_doutb,
    output logic [20:0]            o_sample,
    output logic                   o_sample_valid,
    input  logic                   i_sample_ready,
    output logic [2:0]             o_state
);

    localparam int PW = PHASE_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_INTERP = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_phase;
    logic [7:0]    r_frac;
    logic [20:0]   r_a;
    logic [20:0]   r_b;
    logic [20:0]   r_sample;
    logic          r_sample_valid;

    logic [7:0]         w_idx;
    logic [7:0]         w_frac_now;
    logic               w_handshake;
    logic signed [21:0] w_diff;
    logic signed [30:0] w_prod;
    logic signed [30:0] w_shift;
    logic [20:0]        w_interp;
    logic               w_unused;

    assign w_idx       = r_phase[PW-1:PW-8];
    assign w_frac_now  = r_phase[PW-9:PW-16];
    assign w_handshake = (r_state == S_OUT) && i_sample_ready;

    // Blend: a + ((b - a) * frac) >>> 8. The result always lies between a
    // and b, so keeping the low 21 bits of the shifted step is exact.
    assign w_diff   = $signed({r_b[20], r_b}) - $signed({r_a[20], r_a});
    assign w_prod   = w_diff * $signed({1'b0, r_frac});
    assign w_shift  = w_prod >>> 8;
    assign w_interp = r_a + w_shift[20:0];
    assign w_unused = ^w_shift[30:21];

    assign o_sample       = r_sample;
    assign o_sample_valid = r_sample_valid;
    assign o_state        = r_state;

    // Phase accumulator: clear has priority over the per-sample advance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase <= '0;
        end else if (i_phase_clear) begin
            r_phase <= '0;
        end else if (w_handshake) begin
            r_phase <= r_phase + i_fcw;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and LUT port drive (ports only active in FETCH).
    always_comb begin
        w_next      = r_state;
        o_lut_ena   = 1'b0;
        o_lut_enb   = 1'b0;
        o_lut_addra = 8'd0;
        o_lut_addrb = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                o_lut_ena   = 1'b1;
                o_lut_enb   = 1'b1;
                o_lut_addra = w_idx;
                o_lut_addrb = w_idx + 8'd1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                w_next = S_INTERP;
            end
            S_INTERP: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                if (i_sample_ready) begin
                    w_next = i_enable ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latch frac at fetch, LUT words at wait, sample at interp.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frac         <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            if (r_state == S_FETCH) begin
                r_frac <= w_frac_now;
            end
            if (r_state == S_WAIT) begin
                r_a <= i_lut_douta;
                r_b <= i_lut_doutb;
            end
            if (r_state == S_INTERP) begin
                r_sample       <= w_interp;
                r_sample_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sine_nco.sv
// Bench for sine_nco: behavioural dual-port LUT, directed vectors with
// hand-computed samples and LUT addresses, scoreboard queues drained by a
// monitor on the falling edge.
module tb_sine_nco;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [23:0] fcw;
  logic        phase_clear;
  logic        lut_ena;
  logic [7:0]  lut_addra;
  logic [20:0] lut_douta;
  logic        lut_enb;
  logic [7:0]  lut_addrb;
  logic [20:0] lut_doutb;
  logic [20:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = -1;
  logic chk_period = 1'b0;

  logic [20:0] exp_q[$];
  logic [15:0] addr_q[$];
  logic [20:0] exp_s;
  logic [15:0] exp_a;
  logic [20:0] mem [256];

  sine_nco #(.PHASE_WIDTH(24)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .i_fcw          (fcw),
    .i_phase_clear  (phase_clear),
    .o_lut_ena      (lut_ena),
    .o_lut_addra    (lut_addra),
    .i_lut_douta    (lut_douta),
    .o_lut_enb      (lut_enb),
    .o_lut_addrb    (lut_addrb),
    .i_lut_doutb    (lut_doutb),
    .o_sample       (sample),
    .o_sample_valid (sample_valid),
    .i_sample_ready (sample_ready),
    .o_state        (state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous dual-port LUT, one cycle read latency
  always @(posedge clk) begin
    if (lut_ena) lut_douta <= mem[lut_addra];
    if (lut_enb) lut_doutb <= mem[lut_addrb];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [20:0] s, input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back(s);
    addr_q.push_back({a, b});
  endtask

  task automatic clear_phase();
    phase_clear = 1'b1;
    tick();
    phase_clear = 1'b0;
  endtask

  // let n samples start, then drop enable so the FSM parks in IDLE afterwards
  task automatic run(input int n);
    int cnt;
    cnt = 0;
    enable = 1'b1;
    for (int k = 0; k < 100 * n && cnt < n; k++) begin
      tick();
      if (lut_ena) cnt++;
    end
    enable = 1'b0;
    chk("run_fetch_count", cnt, n);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (state == 3'd0 && !sample_valid && exp_q.size() == 0) done = 1'b1;
      else tick();
    end
    chk("wait_idle", {31'd0, done}, 32'd1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (sample_valid && sample_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: got %0d expected none", $signed(sample));
        end else begin
          exp_s = exp_q.pop_front();
          if (sample !== exp_s) begin
            errors++;
            $display("FAIL sample: got %0d expected %0d", $signed(sample), $signed(exp_s));
          end
        end
        if (chk_period && last_hs >= 0) chk("sample_period", cyc - last_hs, 4);
        last_hs = cyc;
      end
      if (lut_ena || lut_enb) begin
        chk("lut_en_pair", {31'd0, lut_enb}, {31'd0, lut_ena});
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL lut_addr_unexpected: got %0d/%0d expected none", lut_addra, lut_addrb);
        end else begin
          exp_a = addr_q.pop_front();
          if ({lut_addra, lut_addrb} !== exp_a) begin
            errors++;
            $display("FAIL lut_addr: got %0d/%0d expected %0d/%0d",
                     lut_addra, lut_addrb, exp_a[15:8], exp_a[7:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [20:0] held;
    logic ok;
    for (int i = 0; i < 256; i++) mem[i] = 21'(i * 1000);
    rst = 1'b1;
    enable = 1'b0;
    fcw = '0;
    phase_clear = 1'b0;
    sample_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ena", lut_ena, 0);
    chk("rst_enb", lut_enb, 0);
    chk("rst_addra", lut_addra, 0);
    chk("rst_addrb", lut_addrb, 0);
    chk("rst_state", state, 0);

    // integer step: samples 0,1000,...; one sample per 4 cycles
    fcw = 24'h010000;
    for (int i = 0; i < 6; i++) push(21'(i * 1000), 8'(i), 8'(i + 1));
    chk_period = 1'b1;
    last_hs = -1;
    run(6);
    wait_idle();
    chk_period = 1'b0;

    // half step: frac alternates 0x00/0x80
    clear_phase();
    fcw = 24'h008000;
    push(21'd0, 8'd0, 8'd1);
    push(21'd500, 8'd0, 8'd1);
    push(21'd1000, 8'd1, 8'd2);
    push(21'd1500, 8'd1, 8'd2);
    run(4);
    wait_idle();

    // table wrap: 255 pairs with 0
    clear_phase();
    fcw = 24'hFF8000;
    push(21'd0, 8'd0, 8'd1);
    push(21'd127500, 8'd255, 8'd0);
    run(2);
    wait_idle();

    // negative slope
    mem[5] = 21'd100;
    mem[6] = 21'd0;
    clear_phase();
    fcw = 24'h058000;
    push(21'd0, 8'd0, 8'd1);
    push(21'd50, 8'd5, 8'd6);
    run(2);
    wait_idle();
    mem[6] = 21'h1FFFFF;
    clear_phase();
    push(21'd0, 8'd0, 8'd1);
    push(21'd49, 8'd5, 8'd6);
    run(2);
    wait_idle();
    mem[5] = 21'd5000;
    mem[6] = 21'd6000;

    // backpressure: 10 stalled cycles, then exactly one phase step
    clear_phase();
    fcw = 24'h010000;
    sample_ready = 1'b0;
    push(21'd0, 8'd0, 8'd1);
    push(21'd1000, 8'd1, 8'd2);
    enable = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (sample_valid) ok = 1'b1;
    end
    chk("bp_valid_seen", {31'd0, ok}, 32'd1);
    held = sample;
    chk("bp_first_sample", held, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold", {sample_valid, lut_ena, lut_enb, sample}, {3'b100, held});
    end
    sample_ready = 1'b1;
    run(1);
    wait_idle();

    // fcw = 0: constant sample from phase 0x020000
    fcw = 24'h000000;
    for (int i = 0; i < 3; i++) push(21'd2000, 8'd2, 8'd3);
    run(3);
    wait_idle();

    // async reset during WAIT
    addr_q.push_back({8'd2, 8'd3});
    enable = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (lut_ena) ok = 1'b1;
    end
    chk("ar_fetch_seen", {31'd0, ok}, 32'd1);
    tick();
    chk("ar_in_wait", state, 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_state", state, 0);
    chk("ar_outputs", {sample_valid, lut_ena, lut_enb, lut_addra, lut_addrb},
        {3'b000, 16'h0000});
    chk("ar_sample", sample, 0);
    tick();
    rst = 1'b0;
    push(21'd0, 8'd0, 8'd1);
    run(1);
    wait_idle();

    chk("queues_empty", exp_q.size() + addr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
